sextium_mem_arbiter: RTL
========================

Name: sextium_mem_arbiter

Overview:
- Shares the single external 16-bit memory port between two requesters: the CPU core (port C) and a DMA/frame-scanout engine (port D).
- Each requester sees a simple read/write strobe with an ack handshake, identical to the core's mem_read/mem_write/mem_ack bus.
- The arbiter grants round-robin, drives a fixed-wait-state asynchronous SRAM, registers read data, and pulses ack for exactly one cycle.

Parameters:
- WAIT_CYCLES, 2, number of cycles the memory strobes are held per access; legal range 1..15.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_read  in  1  core read request, held until c_ack.
- c_write  in  1  core write request, held until c_ack.
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_rdata  out  DW  core read data, registered.
- c_ack  out  1  one-cycle completion pulse to the core.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ack: same as the c_ signals, for the DMA port.
- m_addr  out  AW  memory address, registered.
- m_wdata  out  DW  memory write data, registered.
- m_rdata  in  DW  memory read data.
- m_ce  out  1  memory chip enable.
- m_oe  out  1  memory output enable (reads only).
- m_we  out  1  memory write enable (writes only).
- grant  out  1  current or last owner: 0 = C, 1 = D.
- state  out  2  FSM state, for visualization.

Behaviour:
- FSM states: IDLE=0, ACCESS=1, DONE=2. Encoding 3 is unused and recovers to IDLE.
- Reset (async, any state, including mid-access):
  - state=IDLE, m_ce=m_oe=m_we=0, c_ack=d_ack=0, c_rdata=d_rdata=0, m_addr=m_wdata=0, wait counter=0.
  - last_grant=1, so C wins the first contended arbitration.
- A port "requests" when read|write is high.
- If both read and write are high on one port, the access is a write.
- IDLE:
  - At a rising edge where any port requests, pick the winner.
  - Only one port requesting: that port wins.
  - Both requesting: the port other than last_grant wins.
  - Latch the winner's addr/wdata/op into m_addr/m_wdata and the op register; set grant and last_grant to the winner; load counter=WAIT_CYCLES-1; go to ACCESS.
  - No request: stay in IDLE, all strobes 0.
- ACCESS:
  - m_ce=1, and m_oe=1 for reads or m_we=1 for writes, held for exactly WAIT_CYCLES cycles.
  - m_addr and m_wdata are stable throughout.
  - The counter decrements each cycle.
  - At the edge where counter==0: for a read, latch m_rdata into the winner's rdata register; go to DONE.
- DONE:
  - All m_ strobes 0. The winner's ack=1 for this single cycle; the other ack stays 0.
  - Next state is IDLE unconditionally. This enforces a one-cycle bus turnaround.
- Latency: request sampled at edge t0 → strobes active cycles t0..t0+W-1 → ack high in the cycle after edge t0+W (W = WAIT_CYCLES).
- Requester rule: drop the request at the edge that samples ack. The arbiter re-arbitrates at the end of the following IDLE cycle, so a dropped request is never re-served.
- Requests that change during ACCESS or DONE are ignored. Only the values latched in IDLE are used.
- rdata holds its value until that port's next read completes. Writes do not modify rdata.
- Back-to-back contention alternates C, D, C, D with W+2 cycles per access. A lone requester also gets one access per W+2 cycles.
- A request on the loser port during an access is served next (no starvation).

Decomposition:
- Shared package sextium_mem_pkg:
  - state encodings ST_IDLE, ST_ACCESS, ST_DONE.
  - port indices PORT_C=0, PORT_D=1.
  - op encoding OP_READ=0, OP_WRITE=1.
- One natural sub-module: sextium_rr_arb2, a combinational 2-way round-robin pick from (req_c, req_d, last_grant) → (valid, winner).
- The FSM, counter and datapath registers stay in the top module.

Test Plan:
- Reset mid-ACCESS with m_we=1 → m_ce/m_we/acks drop immediately (async); after release, state=0 and grant=0.
- C read addr 0x0010 alone, W=2, memory returns 0xBEEF → m_oe high 2 cycles with m_addr=0x0010; c_ack pulses 1 cycle; c_rdata=0xBEEF; d_ack stays 0.
- D write addr 0x8000 data 0x1234, W=2 → m_we high exactly 2 cycles with m_wdata=0x1234; d_ack pulses once; m_oe never high; d_rdata unchanged.
- C and D requesting continuously from reset → grant sequence 0,1,0,1; acks alternate every 4 cycles; no cycle has both acks high.
- C asserts read and write together for addr 0x0003 → treated as a write: m_we=1, m_oe=0.
- W=1, C read → ack 2 edges after sampling; requester drops read on ack; no second access is issued.

Source files
------------

// File: rtl/sextium_mem_pkg.sv
// Shared encodings for the sextium memory arbiter.
// States, port indices and op codes used across the arbiter slice.
package sextium_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic PORT_C   = 1'b0;
  localparam logic PORT_D   = 1'b1;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/sextium_rr_arb2.sv
// Two-way round-robin pick between the core and DMA ports.
// Purely combinational; the caller owns the last_grant register.
module sextium_rr_arb2
  import sextium_mem_pkg::*;
(
  input  logic req_c,
  input  logic req_d,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req_c | req_d;
    winner = PORT_C;
    if (req_c && req_d) begin
      winner = ~last_grant;
    end else if (req_d) begin
      winner = PORT_D;
    end
  end

endmodule

// File: rtl/sextium_mem_arbiter.sv
// Shares one fixed-wait-state async SRAM port between core and DMA.
// IDLE arbitrates, ACCESS holds strobes, DONE acks and turns the bus.
module sextium_mem_arbiter
  import sextium_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_ack,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          m_ce,
  output logic          m_oe,
  output logic          m_we,
  output logic          grant,
  output logic [1:0]    state
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     st_q;
  state_t     st_nx;
  logic [3:0] cnt_q;
  logic       op_q;
  logic       grant_q;
  logic       last_q;
  logic       arb_valid;
  logic       arb_win;
  logic       cnt_zero;
  logic       in_access;

  sextium_rr_arb2 u_arb (
    .req_c      (c_read | c_write),
    .req_d      (d_read | d_write),
    .last_grant (last_q),
    .valid      (arb_valid),
    .winner     (arb_win)
  );

  assign cnt_zero  = (cnt_q == 4'd0);
  assign in_access = (st_q == ST_ACCESS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_nx;
    end
  end

  always_comb begin
    st_nx = ST_IDLE;
    case (st_q)
      ST_IDLE:   st_nx = arb_valid ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: st_nx = cnt_zero ? ST_DONE : ST_ACCESS;
      ST_DONE:   st_nx = ST_IDLE;
      default:   st_nx = ST_IDLE;
    endcase
  end

  // last_q resets to D so the core wins the first contended pick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      op_q    <= OP_READ;
      grant_q <= PORT_C;
      last_q  <= PORT_D;
      m_addr  <= '0;
      m_wdata <= '0;
      c_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (st_q == ST_IDLE && arb_valid) begin
        grant_q <= arb_win;
        last_q  <= arb_win;
        cnt_q   <= CNT_INIT;
        if (arb_win == PORT_D) begin
          m_addr  <= d_addr;
          m_wdata <= d_wdata;
          op_q    <= d_write ? OP_WRITE : OP_READ;
        end else begin
          m_addr  <= c_addr;
          m_wdata <= c_wdata;
          op_q    <= c_write ? OP_WRITE : OP_READ;
        end
      end
      if (in_access && !cnt_zero) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (in_access && cnt_zero && op_q == OP_READ) begin
        if (grant_q == PORT_D) begin
          d_rdata <= m_rdata;
        end else begin
          c_rdata <= m_rdata;
        end
      end
    end
  end

  assign m_ce  = in_access;
  assign m_oe  = in_access && (op_q == OP_READ);
  assign m_we  = in_access && (op_q == OP_WRITE);
  assign c_ack = (st_q == ST_DONE) && (grant_q == PORT_C);
  assign d_ack = (st_q == ST_DONE) && (grant_q == PORT_D);
  assign grant = grant_q;
  assign state = st_q;

endmodule
